row_classifier: RTL and testbench

Sequencing and decision stage directly downstream of `multiplier`. On a start request it walks `row_select` through every output row, pulses `begin_mult` for each, and captures `row_result`/`overflow` when `done_row` rises. It keeps a running maximum and reports the winning row index as the classified digit, together with its score and an overflow summary. It sits between the top-level controller and `multiplier`.

---
 rtl/row_classifier_pkg.sv | 23 ++
 rtl/row_classifier.sv | 130 +++++++++++++
 tb/tb_row_classifier.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/row_classifier_pkg.sv
// ---------------------------------------------------------------------------
// classifier_pkg : shared FSM state type and default sizing for row_classifier
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package classifier_pkg;

  localparam int NUM_ROWS_DEF = 10;
  localparam int SCORE_W_DEF  = 16;
  localparam int ROW_IDX_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/row_classifier.sv
// ---------------------------------------------------------------------------
// row_classifier : scans every row through the multiplier and reports argmax.
// Optional ROW_CLASSIFIER_SATURATE_EN: overflowed rows score as all-ones.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module row_classifier
  import classifier_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int SCORE_W  = SCORE_W_DEF
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 done_row,
  input  logic [SCORE_W-1:0]   row_result,
  input  logic                 overflow,
  output logic                 begin_mult,
  output logic [ROW_IDX_W-1:0] row_select,
  output logic                 busy,
  output logic                 result_valid,
  output logic [ROW_IDX_W-1:0] digit,
  output logic [SCORE_W-1:0]   max_score,
  output logic                 any_overflow
);

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(NUM_ROWS - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [ROW_IDX_W-1:0]   row;
  logic                   done_q;
  logic [SCORE_W-1:0]     score_q;
  logic [SCORE_W-1:0]     captured;
  logic                   done_rise;
  logic                   take_score;

  // done_q follows done_row in every state so a level left high by a
  // previous row can never look like a fresh edge.
  assign done_rise = done_row & ~done_q;

`ifdef ROW_CLASSIFIER_SATURATE_EN
  assign captured = overflow ? {SCORE_W{1'b1}} : row_result;
`else
  assign captured = row_result;
`endif

  // Strict compare keeps the lower index on ties.
  assign take_score = (row == '0) || (score_q > max_score);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      row          <= '0;
      done_q       <= 1'b0;
      score_q      <= '0;
      max_score    <= '0;
      digit        <= '0;
      any_overflow <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_row;
      case (state)
        ST_IDLE: begin
          if (start) begin
            row          <= '0;
            max_score    <= '0;
            digit        <= '0;
            any_overflow <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (done_rise) begin
            score_q      <= captured;
            any_overflow <= any_overflow | overflow;
          end
        end
        ST_COMPARE: begin
          if (take_score) begin
            max_score <= score_q;
            digit     <= row;
          end
          if (row != LAST_ROW) begin
            row <= row + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    begin_mult   = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        begin_mult = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise) state_nxt = ST_COMPARE;
      end
      ST_COMPARE: begin
        state_nxt = (row == LAST_ROW) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        result_valid = 1'b1;
        state_nxt    = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign row_select = row;

endmodule

`default_nettype wire

// File: tb/tb_row_classifier.sv
// ---------------------------------------------------------------------------
// tb_row_classifier : directed scoreboard bench with a behavioural multiplier.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_row_classifier;
  import classifier_pkg::*;

  localparam int NR = NUM_ROWS_DEF;
  localparam int SW = SCORE_W_DEF;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic          done_row;
  logic [SW-1:0] row_result;
  logic          overflow;
  logic          begin_mult;
  logic [3:0]    row_select;
  logic          busy;
  logic          result_valid;
  logic [3:0]    digit;
  logic [SW-1:0] max_score;
  logic          any_overflow;

  row_classifier #(.NUM_ROWS(NR), .SCORE_W(SW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .done_row(done_row),
    .row_result(row_result), .overflow(overflow), .begin_mult(begin_mult),
    .row_select(row_select), .busy(busy), .result_valid(result_valid),
    .digit(digit), .max_score(max_score), .any_overflow(any_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    d;
    logic [SW-1:0] m;
    logic          o;
  } exp_t;

  exp_t          q[$];
  int            errors = 0;
  int            checks = 0;
  int            rv_count = 0;
  int            bm_count = 0;
  int            exp_row = 0;
  int            hold_cycles = 1;
  logic [SW-1:0] sc [16];
  logic          ov [16];
  int            lat [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural multiplier: answers each begin_mult after lat[row] cycles.
  initial begin : model
    int  cnt;
    int  hcnt;
    int  cur;
    logic pend;
    done_row = 1'b0; row_result = '0; overflow = 1'b0;
    pend = 1'b0; hcnt = 0; cnt = 0; cur = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        pend = 1'b0; hcnt = 0; done_row = 1'b0;
      end else begin
        if (hcnt > 0) begin
          hcnt--;
          if (hcnt == 0) done_row = 1'b0;
        end
        if (begin_mult) begin
          check("row_select", 32'(row_select), 32'(exp_row));
          exp_row++;
          bm_count++;
          cur  = int'(row_select);
          cnt  = lat[cur];
          pend = 1'b1;
        end else if (pend) begin
          cnt--;
          if (cnt == 0) begin
            done_row   = 1'b1;
            row_result = sc[cur];
            overflow   = ov[cur];
            hcnt       = hold_cycles;
            pend       = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: every result_valid must match the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        rv_count++;
        if (q.size() == 0) begin
          check("unexpected_result_valid", 32'(result_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check("digit", 32'(digit), 32'(e.d));
          check("max_score", 32'(max_score), 32'(e.m));
          check("any_overflow", 32'(any_overflow), 32'(e.o));
        end
      end
    end
  end

  task automatic set_scores(input int s [NR]);
    for (int i = 0; i < 16; i++) begin
      sc[i] = (i < NR) ? SW'(s[i]) : '0;
      ov[i] = 1'b0;
    end
  endtask

  task automatic set_lat(input int l);
    for (int i = 0; i < 16; i++) lat[i] = l;
  endtask

  task automatic expect_result(input int d, input int m, input int o);
    exp_t e;
    e.d = 4'(d); e.m = SW'(m); e.o = o[0];
    q.push_back(e);
  endtask

  task automatic do_start(input bit immediate);
    if (!immediate) @(posedge clk);
    #1 start = 1'b1;
    bm_count = 0;
    exp_row  = 0;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_result(input int budget);
    int base;
    int n;
    base = rv_count;
    n = 0;
    while (rv_count == base && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (rv_count == base) check("result_timeout", 32'(rv_count - base), 32'd1);
    else check("begin_mult_count", 32'(bm_count), 32'(NR));
  endtask

  initial begin : stim
    int base;
    int n;
    n_rst = 1'b0;
    start = 1'b0;
    set_scores('{0,0,0,0,0,0,0,0,0,0});
    set_lat(3);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_begin_mult", 32'(begin_mult), 32'd0);
    check("rst_row_select", 32'(row_select), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_max_score", 32'(max_score), 32'd0);
    check("rst_any_overflow", 32'(any_overflow), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Ascending scores
    set_scores('{10,20,30,40,50,60,70,80,90,100});
    expect_result(9, 100, 0);
    do_start(0);
    wait_result(6000);

    // All equal, then tie between rows 1 and 2
    set_scores('{784,784,784,784,784,784,784,784,784,784});
    expect_result(0, 784, 0);
    do_start(0);
    wait_result(6000);
    set_scores('{5,900,900,3,1,1,1,1,1,1});
    expect_result(1, 900, 0);
    do_start(0);
    wait_result(6000);

    // Overflow on row 4
    set_scores('{100,100,100,100,392,100,100,500,100,100});
    ov[4] = 1'b1;
`ifdef ROW_CLASSIFIER_SATURATE_EN
    expect_result(4, 16'hFFFF, 1);
`else
    expect_result(7, 500, 1);
`endif
    do_start(0);
    wait_result(6000);

    // done_row held high for 5 cycles, still high into the next row's WAIT
    hold_cycles = 5;
    set_lat(8);
    set_scores('{3,1,4,1,5,9,2,6,5,3});
    expect_result(5, 9, 0);
    do_start(0);
    wait_result(6000);
    hold_cycles = 1;

    // start pulses while busy are ignored
    set_lat(4);
    set_scores('{30,10,60,60,20,0,0,0,0,40});
    expect_result(2, 60, 0);
    do_start(0);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_result(6000);
    repeat (10) @(posedge clk);
    #1 check("idle_after_ignored_start", 32'(busy), 32'd0);

    // Per-row latency 1..400
    set_scores('{7,7,8,2,8,1,0,3,6,5});
    lat[0] = 1;   lat[1] = 400; lat[2] = 2;  lat[3] = 57; lat[4] = 3;
    lat[5] = 199; lat[6] = 8;   lat[7] = 1;  lat[8] = 123; lat[9] = 17;
    expect_result(2, 8, 0);
    do_start(0);
    wait_result(6000);

    // Reset during row 3's WAIT aborts without result_valid
    set_lat(20);
    set_scores('{10,20,30,40,50,60,70,80,90,100});
    base = rv_count;
    do_start(0);
    n = 0;
    while (exp_row < 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_row3", 32'(exp_row), 32'd4);
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_row_select", 32'(row_select), 32'd0);
    check("abort_digit", 32'(digit), 32'd0);
    check("abort_max_score", 32'(max_score), 32'd0);
    check("abort_any_overflow", 32'(any_overflow), 32'd0);
    check("abort_begin_mult", 32'(begin_mult), 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (30) @(posedge clk);
    check("no_result_after_abort", 32'(rv_count), 32'(base));
    set_lat(2);
    set_scores('{100,90,80,70,60,50,40,30,20,10});
    expect_result(0, 100, 0);
    do_start(0);
    wait_result(6000);

    // Back-to-back runs: second start in the cycle after result_valid
    set_lat(3);
    set_scores('{10,10,1000,10,10,10,10,10,10,10});
    ov[2] = 1'b1;
`ifdef ROW_CLASSIFIER_SATURATE_EN
    expect_result(2, 16'hFFFF, 1);
`else
    expect_result(2, 1000, 1);
`endif
    do_start(0);
    wait_result(6000);
    set_scores('{1,2,3,4,5,6,7,8,9,10});
    expect_result(9, 10, 0);
    do_start(1);
    check("b2b_max_cleared", 32'(max_score), 32'd0);
    check("b2b_digit_cleared", 32'(digit), 32'd0);
    check("b2b_ovf_cleared", 32'(any_overflow), 32'd0);
    wait_result(6000);

    repeat (5) @(posedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
